// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between mem_port_arbiter, its two requesters and the memory port.
// The arbiter takes the slave view; whatever drives requests and models memory takes the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 29
);
  logic                  i_req_i;
  logic [ADDR_WIDTH-1:0] i_addr_i;
  logic                  i_gnt_o;
  logic                  i_rvalid_o;
  logic [31:0]           i_rdata_o;
  logic                  flush_i;

  logic                  d_req_i;
  logic                  d_we_i;
  logic [ADDR_WIDTH-1:0] d_addr_i;
  logic [31:0]           d_wdata_i;
  logic [3:0]            d_wstrb_i;
  logic                  d_gnt_o;
  logic                  d_rvalid_o;
  logic [31:0]           d_rdata_o;

  logic                  mem_valid_o;
  logic                  mem_ready_i;
  logic                  mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [31:0]           mem_wdata_o;
  logic [3:0]            mem_wstrb_o;
  logic                  mem_rvalid_i;
  logic [31:0]           mem_rdata_i;

  modport slave (
    input  i_req_i, i_addr_i, flush_i,
    input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_wstrb_i,
    input  mem_ready_i, mem_rvalid_i, mem_rdata_i,
    output i_gnt_o, i_rvalid_o, i_rdata_o,
    output d_gnt_o, d_rvalid_o, d_rdata_o,
    output mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
  );

  modport master (
    output i_req_i, i_addr_i, flush_i,
    output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_wstrb_i,
    output mem_ready_i, mem_rvalid_i, mem_rdata_i,
    input  i_gnt_o, i_rvalid_o, i_rdata_o,
    input  d_gnt_o, d_rvalid_o, d_rdata_o,
    input  mem_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the data stage, one transaction at a time.
// Data has priority, but fetch is guaranteed a turn after MAX_STREAK data grants in a row.
module mem_port_arbiter #(
  parameter int MAX_STREAK = 4,
  parameter int ADDR_WIDTH = 29
) (
  input logic              clk_i,
  input logic              rst_i,
  mem_port_arbiter_if.slave bus
);

  localparam int SW = $clog2(MAX_STREAK + 1);
  typedef logic [SW-1:0] streak_t;
  localparam streak_t STREAK_LIMIT = streak_t'(MAX_STREAK);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  state_t                state_q, state_d;
  logic                  owner_fetch_q, owner_fetch_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  streak_t               streak_q, streak_d;
  logic                  drop_q, drop_d;
  logic                  fetch_wins;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      owner_fetch_q <= 1'b0;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      streak_q      <= '0;
      drop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_fetch_q <= owner_fetch_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      streak_q      <= streak_d;
      drop_q        <= drop_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_fetch_d  = owner_fetch_q;
    addr_d         = addr_q;
    we_d           = we_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    streak_d       = streak_q;
    drop_d         = drop_q;
    fetch_wins     = 1'b0;
    bus.i_gnt_o    = 1'b0;
    bus.d_gnt_o    = 1'b0;
    bus.i_rvalid_o = 1'b0;
    bus.d_rvalid_o = 1'b0;
    bus.mem_valid_o = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.i_req_i || bus.d_req_i) begin
          fetch_wins = bus.i_req_i && (!bus.d_req_i || streak_q == STREAK_LIMIT);
          state_d    = ISSUE;
          if (fetch_wins) begin
            owner_fetch_d = 1'b1;
            addr_d        = bus.i_addr_i;
            we_d          = 1'b0;
            wdata_d       = '0;
            wstrb_d       = '0;
            streak_d      = '0;
          end else begin
            owner_fetch_d = 1'b0;
            addr_d        = bus.d_addr_i;
            we_d          = bus.d_we_i;
            wdata_d       = bus.d_wdata_i;
            wstrb_d       = bus.d_wstrb_i;
            // The streak only grows while fetch is actually left waiting.
            if (!bus.i_req_i) begin
              streak_d = '0;
            end else if (streak_q != STREAK_LIMIT) begin
              streak_d = streak_q + streak_t'(1);
            end
          end
        end
      end

      ISSUE: begin
        bus.mem_valid_o = 1'b1;
        if (bus.flush_i && owner_fetch_q) begin
          drop_d = 1'b1;
        end
        if (bus.mem_ready_i) begin
          bus.i_gnt_o = owner_fetch_q;
          bus.d_gnt_o = !owner_fetch_q;
          state_d     = WAIT_RESP;
        end
      end

      WAIT_RESP: begin
        if (bus.flush_i && owner_fetch_q) begin
          drop_d = 1'b1;
        end
        if (bus.mem_rvalid_i) begin
          // A flush arriving with the response still kills it, hence the direct flush_i term.
          bus.i_rvalid_o = owner_fetch_q && !drop_q && !bus.flush_i;
          bus.d_rvalid_o = !owner_fetch_q;
          drop_d         = 1'b0;
          state_d        = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.mem_wstrb_o = wstrb_q;
  assign bus.i_rdata_o   = bus.mem_rdata_i;
  assign bus.d_rdata_o   = bus.mem_rdata_i;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single external memory port between instruction fetch (read-only requester) and the data stage (read/write requester). It sits between the fetch stage / instruction cache refill path and the data load/store path on one side, and the memory bus on the other. Data has priority, guarded by a starvation counter, and only one transaction is outstanding at a time. A fetch response can be discarded on a pipeline flush.

## Interface
- MAX_STREAK, 4: consecutive data grants allowed while fetch waits; must be ≥1.
- ADDR_WIDTH, 29: word address width, bits [30:2].
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- i_req_i  in  1  fetch request; held stable until i_gnt_o.
- i_addr_i  in  ADDR_WIDTH  fetch word address.
- i_gnt_o  out  1  one-cycle pulse: fetch request accepted by memory.
- i_rvalid_o  out  1  one-cycle pulse: fetch read data valid.
- i_rdata_o  out  32  fetch read data.
- flush_i  in  1  pulse: discard any in-flight fetch response.
- d_req_i  in  1  data request; held stable until d_gnt_o.
- d_we_i  in  1  1 = write.
- d_addr_i  in  ADDR_WIDTH  data word address.
- d_wdata_i  in  32  write data.
- d_wstrb_i  in  4  byte strobes.
- d_gnt_o  out  1  one-cycle pulse: data request accepted.
- d_rvalid_o  out  1  one-cycle pulse: read data valid, or write completion.
- d_rdata_o  out  32  data read data.
- mem_valid_o  out  1  request valid to memory.
- mem_ready_i  in  1  memory accepts request.
- mem_we_o  out  1  write enable.
- mem_addr_o  out  ADDR_WIDTH  word address.
- mem_wdata_o  out  32  write data.
- mem_wstrb_o  out  4  strobes; 0 for fetch reads.
- mem_rvalid_i  in  1  response (read data or write ack).
- mem_rdata_i  in  32  read data.

## Operation
- The FSM has three states: IDLE, ISSUE and WAIT_RESP.
- **IDLE**
  - If any request is present, arbitrate, latch the winner's owner, address, we, wdata and wstrb into registers, and go to ISSUE.
  - A fetch request latches we=0 and wstrb=0.
- **Arbitration**
  - Data wins, except when i_req_i=1 and streak==MAX_STREAK. In that case fetch wins.
  - Fetch wins when it is the only requester.
- **Streak counter**
  - Width is clog2(MAX_STREAK+1).
  - Increments (saturating) when data wins while i_req_i=1.
  - Clears when fetch wins, or at an arbitration where i_req_i=0.
  - Holds value between arbitrations.
- **ISSUE**
  - mem_valid_o=1 and mem_* are driven from the latched registers.
  - When mem_ready_i=1: pulse the owner's gnt for that cycle and go to WAIT_RESP.
  - mem_* stay stable while waiting for mem_ready_i.
- **WAIT_RESP**
  - mem_valid_o=0.
  - When mem_rvalid_i=1: go to IDLE and route the response to the owner.
    - owner=data: d_rvalid_o=mem_rvalid_i; d_rdata_o=mem_rdata_i (combinational).
    - owner=fetch: i_rvalid_o=mem_rvalid_i & !drop & !flush_i; i_rdata_o=mem_rdata_i.
- **Drop flag**
  - Set by flush_i while owner=fetch in ISSUE or WAIT_RESP.
  - Cleared on entry to IDLE.
  - The bus transaction always completes; a valid request is never retracted.
- flush_i has no effect in IDLE, or when owner=data.
- mem_rvalid_i outside WAIT_RESP is ignored: no rvalid, no state change.
- A request withdrawn before arbitration is simply not seen. A request withdrawn after latching still completes on the bus.

## Timing
- **Reset values:** state=IDLE, streak=0, drop=0, owner=data, latched regs=0. mem_valid_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_wstrb_o=0, both gnt=0, both rvalid=0.
  - Asynchronous reset mid-transaction abandons it immediately.
- **Best-case request sequence:**
  - Request seen at edge N (IDLE).
  - mem_valid_o=1 in cycle N+1.
  - With mem_ready_i=1, gnt pulses in cycle N+1.
  - Response is earliest in cycle N+2; rvalid is in the same cycle as mem_rvalid_i.
- **Turnaround:** one IDLE bubble between transactions. Minimum issue-to-issue spacing is 3 cycles.
- gnt and rvalid are never asserted in the same cycle for the same transaction.
- flush_i in the same cycle as mem_rvalid_i suppresses i_rvalid_o.

## Test plan
- **Single fetch:** i_req_i=1, addr 0x100 with zero wait states.
  - mem_valid_o=1 at N+1 with mem_addr_o=0x100, mem_wstrb_o=0, and i_gnt_o at N+1.
  - mem_rdata_i=0x00000013 at N+2 gives i_rvalid_o=1 and i_rdata_o=0x00000013 at N+2.
- **Simultaneous requests, both held continuously, MAX_STREAK=4:**
  - Grants are D,D,D,D,I,D,D,D,D,I.
  - streak reads 4 just before each fetch grant.
- **Data write:** d_we_i=1, addr 0x40, wdata 0xDEADBEEF, wstrb 0b0011, with mem_ready_i low for 3 cycles.
  - mem_* are stable for all 4 cycles.
  - d_gnt_o pulses once; the write ack gives d_rvalid_o=1.
- **Flush:** flush_i pulses while a fetch is in WAIT_RESP.
  - The response arrives; i_rvalid_o stays 0.
  - The next queued data request issues normally.
  - Repeat with flush_i coincident with mem_rvalid_i: still suppressed.
- **Reset mid-ISSUE:** drive rst_i=0 asynchronously between edges.
  - mem_valid_o=0 and all outputs reach reset values without a clock edge.
  - After release, a pending d_req_i issues from IDLE.
- **Stray response:** mem_rvalid_i=1 while in IDLE.
  - No rvalid pulse and no state change.
